sdm_gen: RTL

SDM_GEN -- requirements
Module: sdm_gen

---
 rtl/sdm_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sdm_gen.sv
// sdm_gen: multi-channel delta-sigma bitstream generator.
//
// Each channel divides EXTCLK down to an SDCLK and runs a first- or
// second-order delta-sigma loop. The loop advances once per SDCLK period,
// on the EXTCLK cycle where SDCLK falls, so DSDOUT is stable around every
// SDCLK rising edge. Samples arrive through a one-deep pending slot that
// feeds the active sample register at each loop step.
//
// Ports
//   EXTCLK        in   single clock, rising edge
//   EXTRSTn       in   asynchronous active-low reset
//   EN            in   [CHANNELS]       per-channel run enable
//   ORDER2        in   [CHANNELS]       0 = first order, 1 = second order
//   DIV           in   [CHANNELS*DIVW]  SDCLK half-period minus one
//   SAMPLE        in   [CHANNELS*DW]    signed sample per channel
//   SAMPLE_VALID  in   [CHANNELS]       sample offer
//   SAMPLE_READY  out  [CHANNELS]       pending slot free
//   SDCLK         out  [CHANNELS]       generated modulator clock
//   DSDOUT        out  [CHANNELS]       modulator bitstream
module sdm_gen #(
  parameter int CHANNELS = 2,
  parameter int DW       = 16,
  parameter int DIVW     = 16
) (
  input  logic                     EXTCLK,
  input  logic                     EXTRSTn,
  input  logic [CHANNELS-1:0]      EN,
  input  logic [CHANNELS-1:0]      ORDER2,
  input  logic [CHANNELS*DIVW-1:0] DIV,
  input  logic [CHANNELS*DW-1:0]   SAMPLE,
  input  logic [CHANNELS-1:0]      SAMPLE_VALID,
  output logic [CHANNELS-1:0]      SAMPLE_READY,
  output logic [CHANNELS-1:0]      SDCLK,
  output logic [CHANNELS-1:0]      DSDOUT
);

  localparam int I1W = DW + 2;
  localparam int I2W = DW + 4;
  // Sum widths leave headroom for integrator + input + feedback before
  // saturating back to the integrator width.
  localparam int S1W = DW + 4;
  localparam int S2W = DW + 6;

  localparam logic signed [S1W-1:0] FS1    = S1W'(1) <<< (DW - 1);
  localparam logic signed [S2W-1:0] FS2    = S2W'(1) <<< (DW - 1);
  localparam logic signed [I1W-1:0] I1_MAX = {1'b0, {(I1W-1){1'b1}}};
  localparam logic signed [I1W-1:0] I1_MIN = {1'b1, {(I1W-1){1'b0}}};
  localparam logic signed [I2W-1:0] I2_MAX = {1'b0, {(I2W-1){1'b1}}};
  localparam logic signed [I2W-1:0] I2_MIN = {1'b1, {(I2W-1){1'b0}}};

  function automatic logic signed [I1W-1:0] sat_i1(input logic signed [S1W-1:0] v);
    if (v > S1W'(I1_MAX))      return I1_MAX;
    else if (v < S1W'(I1_MIN)) return I1_MIN;
    else                       return I1W'(v);
  endfunction

  function automatic logic signed [I2W-1:0] sat_i2(input logic signed [S2W-1:0] v);
    if (v > S2W'(I2_MAX))      return I2_MAX;
    else if (v < S2W'(I2_MIN)) return I2_MIN;
    else                       return I2W'(v);
  endfunction

  // Low during the first cycle after reset release: that cycle loads the
  // divider shadows and keeps the sample handshake closed.
  logic run_q;

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic        [DIVW-1:0] div_in;
    logic signed [DW-1:0]   smp_in;
    logic        [DIVW-1:0] cnt_q, cnt_d, divs_q, divs_d;
    logic                   sdclk_q, sdclk_d, dout_q, dout_d, pfull_q, pfull_d;
    logic signed [I1W-1:0]  i1_q, i1_d;
    logic signed [I2W-1:0]  i2_q, i2_d;
    logic signed [DW-1:0]   act_q, act_d, pend_q, pend_d;
    logic                   live, wrap, step, xfer, y;
    logic signed [S1W-1:0]  fb1, i1_sum;
    logic signed [S2W-1:0]  fb2, i2_sum;

    always_comb begin
      div_in = DIV[k*DIVW +: DIVW];
      smp_in = SAMPLE[k*DW +: DW];
      live   = run_q & EN[k];
      wrap   = (cnt_q == divs_q);
      step   = live & wrap & sdclk_q;
      xfer   = SAMPLE_VALID[k] & run_q & ~pfull_q;
      y      = ORDER2[k] ? ~i2_q[I2W-1] : ~i1_q[I1W-1];
      fb1    = y ? FS1 : -FS1;
      fb2    = y ? FS2 : -FS2;
      // Both sums use pre-step integrator values.
      i1_sum = S1W'(i1_q) + S1W'(act_q) - fb1;
      i2_sum = S2W'(i2_q) + S2W'(i1_q) - fb2;

      cnt_d   = cnt_q;
      divs_d  = divs_q;
      sdclk_d = sdclk_q;
      dout_d  = dout_q;
      i1_d    = i1_q;
      i2_d    = i2_q;
      act_d   = act_q;
      pend_d  = pend_q;
      pfull_d = pfull_q;

      if (!live) begin
        cnt_d   = '0;
        divs_d  = div_in;
        sdclk_d = 1'b0;
        dout_d  = 1'b0;
        i1_d    = '0;
        i2_d    = '0;
      end else if (wrap) begin
        // The shadow only reloads here, so a DIV change never cuts the
        // half-period in progress.
        cnt_d   = '0;
        divs_d  = div_in;
        sdclk_d = ~sdclk_q;
        if (sdclk_q) begin
          dout_d = y;
          i1_d   = sat_i1(i1_sum);
          if (ORDER2[k]) i2_d = sat_i2(i2_sum);
        end
      end else begin
        cnt_d = cnt_q + DIVW'(1);
      end

      // Promotion happens after the step has consumed the old active value.
      if (step && pfull_q) begin
        act_d   = pend_q;
        pfull_d = 1'b0;
      end
      if (xfer) begin
        pend_d  = smp_in;
        pfull_d = 1'b1;
      end
    end

    always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
      if (!EXTRSTn) begin
        cnt_q   <= '0;
        divs_q  <= '0;
        sdclk_q <= 1'b0;
        dout_q  <= 1'b0;
        i1_q    <= '0;
        i2_q    <= '0;
        act_q   <= '0;
        pfull_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        divs_q  <= divs_d;
        sdclk_q <= sdclk_d;
        dout_q  <= dout_d;
        i1_q    <= i1_d;
        i2_q    <= i2_d;
        act_q   <= act_d;
        pfull_q <= pfull_d;
      end
    end

    // Pending data is only ever read when pfull_q qualifies it.
    always_ff @(posedge EXTCLK) begin
      pend_q <= pend_d;
    end

    assign SAMPLE_READY[k] = run_q & ~pfull_q;
    assign SDCLK[k]        = sdclk_q;
    assign DSDOUT[k]       = dout_q;
  end

endmodule
